twiddle_angle_sched: RTL and testbench
======================================

// Module: twiddle_angle_sched
// PURPOSE
// - Sequences the per-stage twiddle angle indices that feed the CORDIC/int-to-float twiddle pipe.
// - One start request produces all NFFT/2 butterfly angles of one FFT stage, PARL lanes per beat.
// - Uses credit-based flow control so the pipe never holds more than PIPE_DEPTH beats in flight.
// - Sits between the FFT stage controller (start/stage/done) and the twiddle pipe input.
// PARAMETERS
// - NFFT        256  FFT size, power of two, >= 16.
// - PARL        1    Parallel lanes per beat; power of two; NFFT/2 divisible by PARL.
// - PIPE_DEPTH  16   Downstream beat capacity = initial credit count, >= 1.
// - MIN_STAGE   3    Lowest stage served (stages 1 and 2 need no CORDIC).
// PORTS
// - clk           in   1                        Clock.
// - rst           in   1                        Reset, synchronous, active-high.
// - start         in   1                        Stage request pulse; sampled only in IDLE.
// - stage         in   $clog2(LOG2N+1)          Stage number s (1-based, DIT), LOG2N=$clog2(NFFT).
// - busy          out  1                        High in RUN or DRAIN.
// - done          out  1                        One-cycle pulse when all beats are emitted and all credits have returned.
// - err           out  1                        One-cycle pulse: start with s<MIN_STAGE or s>LOG2N.
// - ang_tdata     out  [PARL][LOG2N-1:0]        Angle index k per lane (angle = 2*pi*k/NFFT).
// - ang_tvalid    out  1                        Beat valid.
// - ang_tlast     out  1                        Last beat of the stage.
// - ang_tready    in   1                        Pipe accepts the beat.
// - cred_ret      in   1                        Pulse: one beat has left the pipe output; returns one credit.
// BEHAVIOUR
// - Reset: IDLE; busy=0, done=0, err=0, ang_tvalid=0, ang_tlast=0, ang_tdata=0; credits=PIPE_DEPTH; beat counter=0.
// - FSM: IDLE -> RUN on start with valid stage; stage is latched, shift=LOG2N-s.
// - Invalid stage: err pulses on the next cycle; FSM stays IDLE.
// - RUN -> DRAIN on acceptance of the tlast beat.
// - DRAIN -> IDLE when credits==PIPE_DEPTH; done pulses in that same transition cycle.
// - start in RUN or DRAIN: ignored, no err.
// - Angle rule: beat n, lane i, butterfly b=n*PARL+i: k=(b mod 2^(s-1)) << shift. Result is always < NFFT/2.
// - Beats per stage: NFFT/(2*PARL). ang_tlast=1 only on beat NFFT/(2*PARL)-1.
// - ang_tvalid = (state==RUN) && credits>0. Registered output; the first valid appears 1 cycle after start is accepted.
// - AXI-S rules:
//   - Once tvalid is asserted, tdata and tlast hold stable until tvalid&&tready.
//   - tvalid does not drop before the handshake, because credits only decrement on a handshake.
// - Throughput: 1 beat/cycle while tready=1 and credits>0.
// - Credits:
//   - handshake only: -1.
//   - cred_ret only: +1.
//   - both in the same cycle: unchanged.
//   - cred_ret at credits==PIPE_DEPTH: ignored; assertion fires in simulation.
// - cred_ret is accepted in every state, including IDLE.
// - Reset mid-operation: immediate return to the reset state. In-flight credits are discarded; the pipe is reset together with this block.
// STRUCTURE
// - Package twiddle_pkg:
//   - typedef enum {IDLE,RUN,DRAIN} tw_sched_state_t.
//   - MIN_CORDIC_STAGE=3.
//   - function tw_angle(b,s,log2n).
// - Sub-module tw_credit_cnt (params DEPTH; ports take, give, avail, full); counter width $clog2(DEPTH+1).
// - Top level holds the FSM, the beat counter, the stage/shift registers and the output registers.
// TESTING
// - NFFT=16, PARL=1, stage=3, tready=1, cred_ret echoed 4 cycles later:
//   - k=0,2,4,6,0,2,4,6 over 8 beats; tlast on beat 7; done once.
// - NFFT=16, PARL=1, stage=4: k=0..7 in order; stage=3 then rerun gives identical sequence.
// - NFFT=16, PARL=2, stage=3: beats {0,2},{4,6},{0,2},{4,6}; tlast on beat 3.
// - PIPE_DEPTH=4, cred_ret held 0:
//   - exactly 4 beats, then tvalid=0, busy=1.
//   - one cred_ret pulse -> exactly one more beat.
// - Random tready stalls: tdata/tlast stable while tvalid&&!tready. Same cycle handshake+cred_ret leaves credits unchanged.
// - start with stage=2 or stage=5 (NFFT=16): err pulse, no tvalid. start during RUN ignored.
// - rst asserted mid-RUN: next cycle all outputs at reset values, credits=PIPE_DEPTH; a fresh start runs the full sequence.

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared types and helpers for the twiddle angle scheduler.
package twiddle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tw_sched_state_t;

  // Stages 1 and 2 use trivial twiddles and bypass the CORDIC pipe.
  localparam int unsigned MIN_CORDIC_STAGE = 3;

  // Angle index for butterfly b of DIT stage s: (b mod 2^(s-1)) << (log2n-s).
  function automatic int unsigned tw_angle(input int unsigned b,
                                           input int unsigned s,
                                           input int unsigned log2n);
    int unsigned mask;
    mask = (32'd1 << (s - 1)) - 32'd1;
    return (b & mask) << (log2n - s);
  endfunction

endpackage

// File: rtl/tw_credit_cnt.sv
// Credit counter: starts full, take consumes one credit, give returns one.
module tw_credit_cnt #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          take,
  input  logic          give,
  output logic [CW-1:0] avail,
  output logic          full
);

  logic give_ok;

  assign full    = (avail == CW'(DEPTH));
  // A return with every credit already home is dropped.
  assign give_ok = give & ~full;

  // Credit count update; simultaneous take and give cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      avail <= CW'(DEPTH);
    end else if (take && !give_ok) begin
      avail <= avail - 1'b1;
    end else if (give_ok && !take) begin
      avail <= avail + 1'b1;
    end
  end

  // Flag credit returns that arrive while the counter is already full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(give && full)) else $error("credit returned with all credits home");
    end
  end

endmodule

// File: rtl/twiddle_angle_sched.sv
// Twiddle angle scheduler: emits the NFFT/2 angle indices of one FFT stage,
// PARL lanes per beat, throttled by credits returned from the twiddle pipe.
module twiddle_angle_sched
  import twiddle_pkg::*;
#(
  parameter  int unsigned NFFT       = 256,
  parameter  int unsigned PARL       = 1,
  parameter  int unsigned PIPE_DEPTH = 16,
  parameter  int unsigned MIN_STAGE  = MIN_CORDIC_STAGE,
  localparam int unsigned LOG2N      = $clog2(NFFT),
  localparam int unsigned SW         = $clog2(LOG2N + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SW-1:0]               stage,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [PARL-1:0][LOG2N-1:0]  ang_tdata,
  output logic                        ang_tvalid,
  output logic                        ang_tlast,
  input  logic                        ang_tready,
  input  logic                        cred_ret
);

  localparam int unsigned BEATS = NFFT / (2 * PARL);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW    = $clog2(PIPE_DEPTH + 1);

  tw_sched_state_t             state, state_n;
  logic [BW-1:0]               beat;
  logic [SW-1:0]               stage_q;
  logic [PARL-1:0][LOG2N-1:0]  data_n;
  logic                        last_n;
  logic                        hs, accept, bad, full;
  logic [CW-1:0]               avail;

  assign hs     = ang_tvalid & ang_tready;
  assign bad    = (stage < SW'(MIN_STAGE)) || (stage > SW'(LOG2N));
  assign accept = (state == IDLE) && start && !bad;

  assign busy       = (state != IDLE);
  assign done       = (state == DRAIN) && full;
  assign ang_tvalid = (state == RUN) && (avail != '0);

  tw_credit_cnt #(.DEPTH(PIPE_DEPTH)) u_cred (
    .clk   (clk),
    .rst   (rst),
    .take  (hs),
    .give  (cred_ret),
    .avail (avail),
    .full  (full)
  );

  // Angles for the beat to be presented next: beat 0 of the requested stage
  // on acceptance, otherwise the beat following the current one.
  always_comb begin
    int unsigned s;
    int unsigned nb;
    s  = accept ? 32'(stage) : 32'(stage_q);
    nb = accept ? 32'd0 : 32'(beat) + 32'd1;
    for (int unsigned i = 0; i < PARL; i++) begin
      data_n[i] = LOG2N'(tw_angle(nb * PARL + i, s, LOG2N));
    end
    last_n = (nb == BEATS - 1);
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (hs && ang_tlast) state_n = DRAIN;
      DRAIN:   if (full) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, stage latch, beat counter and output registers; the beat only
  // advances on a handshake so data and last stay stable under stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      stage_q   <= '0;
      ang_tdata <= '0;
      ang_tlast <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      err   <= (state == IDLE) && start && bad;
      if (accept) begin
        stage_q   <= stage;
        beat      <= '0;
        ang_tdata <= data_n;
        ang_tlast <= last_n;
      end else if (hs) begin
        if (ang_tlast) begin
          beat      <= '0;
          ang_tdata <= '0;
          ang_tlast <= 1'b0;
        end else begin
          beat      <= beat + 1'b1;
          ang_tdata <= data_n;
          ang_tlast <= last_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_twiddle_angle_sched.sv
// Scoreboard bench for twiddle_angle_sched: instance A (NFFT=16, PARL=1,
// PIPE_DEPTH=4) and instance B (NFFT=16, PARL=2, PIPE_DEPTH=16).
module tb_twiddle_angle_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  // Instance A
  logic            a_start = 1'b0;
  logic [2:0]      a_stage = '0;
  logic            a_busy, a_done, a_err, a_tvalid, a_tlast;
  logic [0:0][3:0] a_tdata;
  logic            a_tready = 1'b0;
  logic            a_man = 1'b0;
  logic            a_echo = 1'b0;
  logic            a_cred;
  logic [3:0]      a_dly;

  // Instance B
  logic            b_start = 1'b0;
  logic [2:0]      b_stage = '0;
  logic            b_busy, b_done, b_err, b_tvalid, b_tlast;
  logic [1:0][3:0] b_tdata;
  logic            b_tready = 1'b0;
  logic            b_cred;
  logic [3:0]      b_dly;

  assign a_cred = a_echo ? a_dly[3] : a_man;
  assign b_cred = b_dly[3];

  twiddle_angle_sched #(.NFFT(16), .PARL(1), .PIPE_DEPTH(4), .MIN_STAGE(3)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .stage(a_stage),
    .busy(a_busy), .done(a_done), .err(a_err),
    .ang_tdata(a_tdata), .ang_tvalid(a_tvalid), .ang_tlast(a_tlast),
    .ang_tready(a_tready), .cred_ret(a_cred)
  );

  twiddle_angle_sched #(.NFFT(16), .PARL(2), .PIPE_DEPTH(16), .MIN_STAGE(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stage(b_stage),
    .busy(b_busy), .done(b_done), .err(b_err),
    .ang_tdata(b_tdata), .ang_tvalid(b_tvalid), .ang_tlast(b_tlast),
    .ang_tready(b_tready), .cred_ret(b_cred)
  );

  // Pipe model: each accepted beat returns its credit 4 cycles later.
  always @(posedge clk) begin
    if (rst) begin
      a_dly <= '0;
      b_dly <= '0;
    end else begin
      a_dly <= {a_dly[2:0], a_tvalid & a_tready};
      b_dly <= {b_dly[2:0], b_tvalid & b_tready};
    end
  end

  logic [4:0] qa[$];
  logic [8:0] qb[$];

  function automatic logic [3:0] exp_k(input int b, input int s);
    return 4'((b % (1 << (s - 1))) << (4 - s));
  endfunction

  task automatic push_a(input int s);
    for (int n = 0; n < 8; n++) qa.push_back({(n == 7), exp_k(n, s)});
  endtask

  task automatic push_b(input int s);
    for (int n = 0; n < 4; n++) qb.push_back({(n == 3), exp_k(2 * n + 1, s), exp_k(2 * n, s)});
  endtask

  // Monitor A: scoreboard pop, stall stability, credit model.
  int         a_beats = 0;
  int         a_cm = 4;
  logic       a_pstall = 1'b0;
  logic [4:0] a_hold, a_exp;
  always @(negedge clk) begin
    if (rst) begin
      a_cm = 4;
      a_pstall = 1'b0;
    end else begin
      asserts++;
      if (dut_a.u_cred.avail !== 3'(a_cm)) begin
        fails++;
        $display("FAIL a_credits: got %0d expected %0d", dut_a.u_cred.avail, a_cm);
      end
      if (a_pstall) begin
        asserts++;
        if ({a_tlast, a_tdata} !== a_hold) begin
          fails++;
          $display("FAIL a_stall_stable: got %h expected %h", {a_tlast, a_tdata}, a_hold);
        end
      end
      if (a_tvalid && a_tready) begin
        asserts++;
        a_beats++;
        if (qa.size() == 0) begin
          fails++;
          $display("FAIL a_unexpected_beat: got %h expected none", {a_tlast, a_tdata});
        end else begin
          a_exp = qa.pop_front();
          if ({a_tlast, a_tdata} !== a_exp) begin
            fails++;
            $display("FAIL a_beat: got last/k %h expected %h", {a_tlast, a_tdata}, a_exp);
          end
        end
      end
      a_pstall = a_tvalid && !a_tready;
      a_hold   = {a_tlast, a_tdata};
      if (a_tvalid && a_tready) a_cm = a_cm - 1;
      if (a_cred && a_cm < 4 + int'(a_tvalid && a_tready)) a_cm = a_cm + 1;
    end
  end

  // Monitor B: scoreboard pop.
  int         b_beats = 0;
  logic [8:0] b_exp;
  always @(negedge clk) begin
    if (!rst && b_tvalid && b_tready) begin
      asserts++;
      b_beats++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected_beat: got %h expected none", {b_tlast, b_tdata});
      end else begin
        b_exp = qb.pop_front();
        if ({b_tlast, b_tdata} !== b_exp) begin
          fails++;
          $display("FAIL b_beat: got last/k1/k0 %h expected %h", {b_tlast, b_tdata}, b_exp);
        end
      end
    end
  end

  task automatic start_a(input int s);
    a_stage = 3'(s);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_idle_a(input bit rnd, output int dcnt, output bit to);
    dcnt = 0;
    to   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rnd) a_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (a_done) dcnt++;
      if (!a_busy) begin
        to = 1'b0;
        break;
      end
    end
    a_tready = 1'b1;
  endtask

  task automatic test_reset();
    asserts++;
    if ({a_busy, a_done, a_err, a_tvalid, a_tlast} !== 5'b0) begin
      fails++;
      $display("FAIL reset_a_ctrl: got %b expected 00000", {a_busy, a_done, a_err, a_tvalid, a_tlast});
    end
    asserts++;
    if (a_tdata !== '0) begin
      fails++;
      $display("FAIL reset_a_tdata: got %h expected 0", a_tdata);
    end
    asserts++;
    if ({b_busy, b_done, b_err, b_tvalid, b_tlast, b_tdata} !== 13'b0) begin
      fails++;
      $display("FAIL reset_b: got %h expected 0", {b_busy, b_done, b_err, b_tvalid, b_tlast, b_tdata});
    end
  endtask

  task automatic run_a_full(input string name, input int s, input bit rnd);
    int dcnt;
    bit to;
    a_beats = 0;
    push_a(s);
    start_a(s);
    asserts++;
    if (a_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL %s_first_valid: got %b expected 1", name, a_tvalid);
    end
    wait_idle_a(rnd, dcnt, to);
    asserts++;
    if (to || dcnt != 1 || a_beats != 8 || qa.size() != 0) begin
      fails++;
      $display("FAIL %s_end: timeout %0d done %0d beats %0d left %0d expected 0 1 8 0",
               name, to, dcnt, a_beats, qa.size());
    end
  endtask

  task automatic test_stage3_echo();
    a_echo = 1'b1;
    a_tready = 1'b1;
    run_a_full("stage3", 3, 1'b0);
  endtask

  task automatic test_stage4_rerun();
    run_a_full("stage4", 4, 1'b0);
    run_a_full("stage3_rerun", 3, 1'b0);
  endtask

  task automatic test_parl2();
    int dcnt = 0;
    bit to = 1'b1;
    b_tready = 1'b1;
    b_beats = 0;
    push_b(3);
    b_stage = 3'd3;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    asserts++;
    if (b_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL parl2_first_valid: got %b expected 1", b_tvalid);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_done) dcnt++;
      if (!b_busy) begin
        to = 1'b0;
        break;
      end
    end
    asserts++;
    if (to || dcnt != 1 || b_beats != 4 || qb.size() != 0) begin
      fails++;
      $display("FAIL parl2_end: timeout %0d done %0d beats %0d left %0d expected 0 1 4 0",
               to, dcnt, b_beats, qb.size());
    end
  endtask

  task automatic test_credit_hold();
    int dcnt = 0;
    int d2;
    bit to;
    a_echo = 1'b0;
    a_man = 1'b0;
    a_tready = 1'b1;
    a_beats = 0;
    push_a(3);
    start_a(3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    asserts++;
    if (a_beats != 4 || a_tvalid !== 1'b0 || a_busy !== 1'b1) begin
      fails++;
      $display("FAIL hold_stop: beats %0d tvalid %b busy %b expected 4 0 1", a_beats, a_tvalid, a_busy);
    end
    @(posedge clk); #1 a_man = 1'b1;
    @(posedge clk); #1 a_man = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    asserts++;
    if (a_beats != 5 || a_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL hold_one_more: beats %0d tvalid %b expected 5 0", a_beats, a_tvalid);
    end
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 a_man = 1'b1;
      @(posedge clk); #1 a_man = 1'b0;
      @(negedge clk);
      if (a_done) dcnt++;
    end
    wait_idle_a(1'b0, d2, to);
    asserts++;
    if (to || dcnt + d2 != 1 || a_beats != 8 || qa.size() != 0) begin
      fails++;
      $display("FAIL hold_end: timeout %0d done %0d beats %0d left %0d expected 0 1 8 0",
               to, dcnt + d2, a_beats, qa.size());
    end
    a_echo = 1'b1;
  endtask

  task automatic test_stalls();
    int dcnt;
    bit to;
    a_beats = 0;
    push_a(4);
    start_a(4);
    wait_idle_a(1'b1, dcnt, to);
    asserts++;
    if (to || dcnt != 1 || a_beats != 8 || qa.size() != 0) begin
      fails++;
      $display("FAIL stalls_end: timeout %0d done %0d beats %0d left %0d expected 0 1 8 0",
               to, dcnt, a_beats, qa.size());
    end
  endtask

  task automatic test_err();
    int bad_stage[2] = '{2, 5};
    foreach (bad_stage[j]) begin
      start_a(bad_stage[j]);
      asserts++;
      if (a_err !== 1'b1 || a_tvalid !== 1'b0 || a_busy !== 1'b0) begin
        fails++;
        $display("FAIL err_stage%0d: err %b tvalid %b busy %b expected 1 0 0",
                 bad_stage[j], a_err, a_tvalid, a_busy);
      end
      @(posedge clk); #1;
      asserts++;
      if (a_err !== 1'b0 || a_tvalid !== 1'b0) begin
        fails++;
        $display("FAIL err_pulse%0d: err %b tvalid %b expected 0 0", bad_stage[j], a_err, a_tvalid);
      end
    end
  endtask

  task automatic test_start_in_run();
    int dcnt;
    bit to;
    a_beats = 0;
    push_a(4);
    start_a(4);
    repeat (2) @(posedge clk);
    #1;
    start_a(2);
    asserts++;
    if (a_err !== 1'b0) begin
      fails++;
      $display("FAIL run_start_err: got %b expected 0", a_err);
    end
    start_a(3);
    wait_idle_a(1'b0, dcnt, to);
    asserts++;
    if (to || dcnt != 1 || a_beats != 8 || qa.size() != 0) begin
      fails++;
      $display("FAIL run_start_end: timeout %0d done %0d beats %0d left %0d expected 0 1 8 0",
               to, dcnt, a_beats, qa.size());
    end
  endtask

  task automatic test_reset_midrun();
    push_a(3);
    start_a(3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete();
    asserts++;
    if ({a_busy, a_done, a_err, a_tvalid, a_tlast} !== 5'b0 || a_tdata !== '0) begin
      fails++;
      $display("FAIL midrun_reset_out: got %b/%h expected 0/0",
               {a_busy, a_done, a_err, a_tvalid, a_tlast}, a_tdata);
    end
    asserts++;
    if (dut_a.u_cred.avail !== 3'd4) begin
      fails++;
      $display("FAIL midrun_reset_credits: got %0d expected 4", dut_a.u_cred.avail);
    end
    run_a_full("post_reset", 3, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    test_stage3_echo();
    test_stage4_rerun();
    test_parl2();
    test_credit_hold();
    test_stalls();
    test_err();
    test_start_in_run();
    test_reset_midrun();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
